semaforo_lamp_driver: RTL

Downstream stage of the `semaforo` traffic-light FSM. It takes the FSM's coded light outputs (`c1`, `c2`, `p1`, `p2`) and drives the individual lamps:
- one-hot red/yellow/green per avenue;
- red/green per pedestrian crossing, with a flashing-green clearance interval after every walk phase.

It also acts as an independent safety monitor. A persistent conflicting light combination latches a fault mode that flashes yellow on both avenues until reset.

---
 rtl/semaforo_pkg.sv | 17 +
 rtl/semaforo_lamp_driver_blink_gen.sv | 27 ++
 rtl/semaforo_lamp_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// Shared light codes and state encodings for the semaforo lamp driver.
package semaforo_pkg;
    localparam logic [1:0] LUZ_VERDE   = 2'b11;
    localparam logic [1:0] LUZ_AMARELO = 2'b10;

    localparam logic [1:0] PED_STOP  = 2'd0;
    localparam logic [1:0] PED_WALK  = 2'd1;
    localparam logic [1:0] PED_CLEAR = 2'd2;

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FAULT  = 1'b1;

    // Codes 00 and 01 both mean red.
    function automatic logic is_red(input logic [1:0] c);
        return !c[1];
    endfunction
endpackage

// File: rtl/semaforo_lamp_driver_blink_gen.sv
// Free-running blink source: tick on counter wrap, phase toggles per tick.
module blink_gen #(
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic phase
);
    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(BLINK_HALF - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/semaforo_lamp_driver.sv
// Lamp driver for the semaforo FSM with a latching conflict monitor.
module semaforo_lamp_driver
    import semaforo_pkg::*;
#(
    parameter int BLINK_HALF   = 25_000_000,
    parameter int CLEAR_BLINKS = 3,
    parameter int FAULT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] c1,
    input  logic [1:0] c2,
    input  logic       p1,
    input  logic       p2,
    output logic       r1,
    output logic       y1,
    output logic       g1,
    output logic       r2,
    output logic       y2,
    output logic       g2,
    output logic       pr1,
    output logic       pg1,
    output logic       pr2,
    output logic       pg2,
    output logic       fault
);
    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam int TW = $clog2(2 * CLEAR_BLINKS + 1);

    logic [1:0]    c1_q, c2_q;
    logic          p1_q, p2_q;
    logic          tick, phase, phase_nxt;
    logic          conflict;
    logic [FW-1:0] fcnt, fcnt_nxt;
    logic [0:0]    st;
    logic          fault_nxt;
    logic [1:0]    p_v, pr_v, pg_v;

    blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .phase(phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q <= '0;
            c2_q <= '0;
            p1_q <= 1'b0;
            p2_q <= 1'b0;
        end else begin
            c1_q <= c1;
            c2_q <= c2;
            p1_q <= p1;
            p2_q <= p2;
        end
    end

    // Lamp registers load from next-state values so they line up with fault.
    assign phase_nxt = phase ^ tick;
    assign conflict  = (!is_red(c1_q) && !is_red(c2_q)) ||
                       (p1_q && !is_red(c1_q)) || (p2_q && !is_red(c2_q));

    always_comb begin
        fcnt_nxt = '0;
        if (conflict)
            fcnt_nxt = (fcnt == FW'(FAULT_CYCLES)) ? fcnt : fcnt + 1'b1;
    end

    assign fault_nxt = (st == ST_FAULT) || (fcnt_nxt == FW'(FAULT_CYCLES));
    assign fault     = (st == ST_FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
            st   <= ST_NORMAL;
            r1 <= 1'b1; y1 <= 1'b0; g1 <= 1'b0;
            r2 <= 1'b1; y2 <= 1'b0; g2 <= 1'b0;
        end else begin
            fcnt <= fcnt_nxt;
            st   <= fault_nxt ? ST_FAULT : ST_NORMAL;
            if (fault_nxt) begin
                r1 <= 1'b0; y1 <= phase_nxt; g1 <= 1'b0;
                r2 <= 1'b0; y2 <= phase_nxt; g2 <= 1'b0;
            end else begin
                r1 <= is_red(c1_q); y1 <= (c1_q == LUZ_AMARELO); g1 <= (c1_q == LUZ_VERDE);
                r2 <= is_red(c2_q); y2 <= (c2_q == LUZ_AMARELO); g2 <= (c2_q == LUZ_VERDE);
            end
        end
    end

    assign p_v = {p2_q, p1_q};

    for (genvar i = 0; i < 2; i++) begin : g_ped
        logic [1:0]    pst, pst_nxt;
        logic [TW-1:0] tcnt, tcnt_nxt;
        logic          pr_q, pg_q;

        // Ticks coinciding with CLEAR entry are not counted: WALK does not look at tick.
        always_comb begin
            pst_nxt  = pst;
            tcnt_nxt = tcnt;
            if (fault_nxt) begin
                pst_nxt = PED_STOP;
            end else begin
                case (pst)
                    PED_STOP:  if (p_v[i]) pst_nxt = PED_WALK;
                    PED_WALK:  if (!p_v[i]) begin
                                   pst_nxt  = PED_CLEAR;
                                   tcnt_nxt = '0;
                               end
                    PED_CLEAR: if (p_v[i]) begin
                                   pst_nxt = PED_WALK;
                               end else if (tick) begin
                                   if (tcnt == TW'(2 * CLEAR_BLINKS - 1)) pst_nxt = PED_STOP;
                                   else tcnt_nxt = tcnt + 1'b1;
                               end
                    default:   pst_nxt = PED_STOP;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pst  <= PED_STOP;
                tcnt <= '0;
                pr_q <= 1'b1;
                pg_q <= 1'b0;
            end else begin
                pst  <= pst_nxt;
                tcnt <= tcnt_nxt;
                pr_q <= (pst_nxt == PED_STOP);
                pg_q <= (pst_nxt == PED_WALK) || ((pst_nxt == PED_CLEAR) && phase_nxt);
            end
        end

        assign pr_v[i] = pr_q;
        assign pg_v[i] = pg_q;
    end

    assign pr1 = pr_v[0];
    assign pg1 = pg_v[0];
    assign pr2 = pr_v[1];
    assign pg2 = pg_v[1];
endmodule
